// File: rtl/williams_input_mapper_pkg.sv
// Shared constants for the Williams input mapper: 9-bit {ext,code} scancodes,
// key-state slot indices, JA/SW bit positions and the coin FSM state type.
package williams_input_pkg;

  localparam int NKEYS  = 24;
  localparam int KIDX_W = 5;

  localparam logic [8:0] SC_HYPER   = 9'h023;
  localparam logic [8:0] SC_FIRE_A  = 9'h01D;
  localparam logic [8:0] SC_FIRE_B  = 9'h014;
  localparam logic [8:0] SC_BOMB_A  = 9'h01C;
  localparam logic [8:0] SC_BOMB_B  = 9'h011;
  localparam logic [8:0] SC_THR_A   = 9'h01B;
  localparam logic [8:0] SC_THR_B   = 9'h16B;
  localparam logic [8:0] SC_THR_C   = 9'h174;
  localparam logic [8:0] SC_UP      = 9'h175;
  localparam logic [8:0] SC_DOWN    = 9'h172;
  localparam logic [8:0] SC_REV     = 9'h029;
  localparam logic [8:0] SC_INV_A   = 9'h012;
  localparam logic [8:0] SC_INV_B   = 9'h059;
  localparam logic [8:0] SC_ADV     = 9'h009;
  localparam logic [8:0] SC_AUTOUP  = 9'h001;
  localparam logic [8:0] SC_SLAM    = 9'h076;
  localparam logic [8:0] SC_HSRST   = 9'h083;
  localparam logic [8:0] SC_ST1_A   = 9'h005;
  localparam logic [8:0] SC_ST1_B   = 9'h016;
  localparam logic [8:0] SC_ST2_A   = 9'h006;
  localparam logic [8:0] SC_ST2_B   = 9'h01E;
  localparam logic [8:0] SC_LCOIN   = 9'h004;
  localparam logic [8:0] SC_RCOIN_A = 9'h00C;
  localparam logic [8:0] SC_RCOIN_B = 9'h02E;

  // One held bit per physical key; functions with several keys OR their slots.
  localparam logic [KIDX_W-1:0] K_HYPER   = 5'd0;
  localparam logic [KIDX_W-1:0] K_FIRE_A  = 5'd1;
  localparam logic [KIDX_W-1:0] K_FIRE_B  = 5'd2;
  localparam logic [KIDX_W-1:0] K_BOMB_A  = 5'd3;
  localparam logic [KIDX_W-1:0] K_BOMB_B  = 5'd4;
  localparam logic [KIDX_W-1:0] K_THR_A   = 5'd5;
  localparam logic [KIDX_W-1:0] K_THR_B   = 5'd6;
  localparam logic [KIDX_W-1:0] K_THR_C   = 5'd7;
  localparam logic [KIDX_W-1:0] K_UP      = 5'd8;
  localparam logic [KIDX_W-1:0] K_DOWN    = 5'd9;
  localparam logic [KIDX_W-1:0] K_REV     = 5'd10;
  localparam logic [KIDX_W-1:0] K_INV_A   = 5'd11;
  localparam logic [KIDX_W-1:0] K_INV_B   = 5'd12;
  localparam logic [KIDX_W-1:0] K_ADV     = 5'd13;
  localparam logic [KIDX_W-1:0] K_AUTOUP  = 5'd14;
  localparam logic [KIDX_W-1:0] K_SLAM    = 5'd15;
  localparam logic [KIDX_W-1:0] K_HSRST   = 5'd16;
  localparam logic [KIDX_W-1:0] K_ST1_A   = 5'd17;
  localparam logic [KIDX_W-1:0] K_ST1_B   = 5'd18;
  localparam logic [KIDX_W-1:0] K_ST2_A   = 5'd19;
  localparam logic [KIDX_W-1:0] K_ST2_B   = 5'd20;
  localparam logic [KIDX_W-1:0] K_LCOIN   = 5'd21;
  localparam logic [KIDX_W-1:0] K_RCOIN_A = 5'd22;
  localparam logic [KIDX_W-1:0] K_RCOIN_B = 5'd23;

  localparam int JA_START2 = 8;
  localparam int JA_INVISO = 7;
  localparam int JA_UP     = 6;
  localparam int JA_DOWN   = 5;
  localparam int JA_REV    = 4;
  localparam int JA_HYPER  = 3;
  localparam int JA_BOMB   = 2;
  localparam int JA_THRUST = 1;
  localparam int JA_FIRE   = 0;

  localparam int SW_START1 = 7;
  localparam int SW_SLAM   = 6;
  localparam int SW_COIN   = 5;
  localparam int SW_HSRST  = 2;
  localparam int SW_ADV    = 1;
  localparam int SW_AUTOUP = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } coin_state_t;

  // Returns {hit, slot}; hit=0 for codes the cabinet does not use.
  function automatic logic [KIDX_W:0] key_lookup(input logic [8:0] code);
    logic [KIDX_W:0] r;
    r = '0;
    case (code)
      SC_HYPER:   r = {1'b1, K_HYPER};
      SC_FIRE_A:  r = {1'b1, K_FIRE_A};
      SC_FIRE_B:  r = {1'b1, K_FIRE_B};
      SC_BOMB_A:  r = {1'b1, K_BOMB_A};
      SC_BOMB_B:  r = {1'b1, K_BOMB_B};
      SC_THR_A:   r = {1'b1, K_THR_A};
      SC_THR_B:   r = {1'b1, K_THR_B};
      SC_THR_C:   r = {1'b1, K_THR_C};
      SC_UP:      r = {1'b1, K_UP};
      SC_DOWN:    r = {1'b1, K_DOWN};
      SC_REV:     r = {1'b1, K_REV};
      SC_INV_A:   r = {1'b1, K_INV_A};
      SC_INV_B:   r = {1'b1, K_INV_B};
      SC_ADV:     r = {1'b1, K_ADV};
      SC_AUTOUP:  r = {1'b1, K_AUTOUP};
      SC_SLAM:    r = {1'b1, K_SLAM};
      SC_HSRST:   r = {1'b1, K_HSRST};
      SC_ST1_A:   r = {1'b1, K_ST1_A};
      SC_ST1_B:   r = {1'b1, K_ST1_B};
      SC_ST2_A:   r = {1'b1, K_ST2_A};
      SC_ST2_B:   r = {1'b1, K_ST2_B};
      SC_LCOIN:   r = {1'b1, K_LCOIN};
      SC_RCOIN_A: r = {1'b1, K_RCOIN_A};
      SC_RCOIN_B: r = {1'b1, K_RCOIN_B};
      default:    r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/williams_input_mapper_if.sv
// Bus bundle between hps_io-side stimulus and the Williams input mapper.
interface williams_input_mapper_if;
  logic [10:0] ps2_key;
  logic [15:0] joy_0;
  logic [15:0] joy_1;
  logic [7:0]  SW;
  logic [8:0]  JA;
  logic [8:0]  JB;

  modport master (output ps2_key, output joy_0, output joy_1,
                  input SW, input JA, input JB);
  modport slave  (input ps2_key, input joy_0, input joy_1,
                  output SW, output JA, output JB);
endinterface

// File: rtl/williams_input_mapper_coin_pulse.sv
// Coin pulse generator: fixed-width pulse per request rising edge, mandatory
// gap afterwards, and a one-deep pending slot for edges arriving meanwhile.
module williams_coin_pulse
  import williams_input_pkg::*;
#(
  parameter logic [23:0] COIN_HOLD = 24'd1_200_000,
  parameter logic [23:0] COIN_GAP  = 24'd1_200_000
)(
  input  logic clk_sys,
  input  logic I_RESET_N,
  input  logic i_req,
  output logic o_pulse
);

  coin_state_t r_state;
  logic [23:0] r_cnt;
  logic        r_pend;
  logic        r_req_d;
  logic        r_pulse;
  logic        w_rise;

  assign w_rise  = i_req & ~r_req_d;
  assign o_pulse = r_pulse;

  always_ff @(posedge clk_sys or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_req_d <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_req_d <= i_req;
      unique case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= HOLD;
            r_cnt   <= COIN_HOLD - 24'd1;
            r_pulse <= 1'b1;
          end
        end
        HOLD: begin
          // Re-setting an already-set pending flag is how extra edges get dropped.
          if (w_rise) r_pend <= 1'b1;
          if (r_cnt == '0) begin
            r_state <= GAP;
            r_cnt   <= COIN_GAP - 24'd1;
            r_pulse <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 24'd1;
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            if (r_pend || w_rise) begin
              r_state <= HOLD;
              r_cnt   <= COIN_HOLD - 24'd1;
              r_pulse <= 1'b1;
              r_pend  <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 24'd1;
            if (w_rise) r_pend <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/williams_input_mapper.sv
// PS/2 + joystick to Williams SW/JA/JB switch inputs. Optional autofire on
// JA[0] is built when INPUT_AUTOFIRE_EN is defined.
module williams_input_mapper
  import williams_input_pkg::*;
#(
  parameter logic [23:0] COIN_HOLD       = 24'd1_200_000,
  parameter logic [23:0] COIN_GAP        = 24'd1_200_000,
  parameter logic [23:0] AUTOFIRE_PERIOD = 24'd2_400_000
)(
  input  logic                    clk_sys,
  input  logic                    I_RESET_N,
  williams_input_mapper_if.slave  bus
);

  if (COIN_HOLD == 24'd0 || COIN_GAP == 24'd0 || AUTOFIRE_PERIOD == 24'd0) begin : g_bad_param
    $error("williams_input_mapper: timing parameters must be nonzero");
  end

  logic             r_armed;
  logic             r_tog;
  logic [NKEYS-1:0] r_keys;
  logic [KIDX_W:0]  w_lookup;
  logic             w_evt;
  logic [15:0]      w_joy;
  logic             w_unused_joy;

  assign w_joy        = bus.joy_0 | bus.joy_1;
  assign w_unused_joy = ^w_joy[15:11];
  assign w_lookup     = key_lookup(bus.ps2_key[8:0]);
  // r_armed suppresses a false event from the toggle value seen during reset.
  assign w_evt        = r_armed & (bus.ps2_key[10] ^ r_tog);

  always_ff @(posedge clk_sys or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_armed <= 1'b0;
      r_tog   <= 1'b0;
      r_keys  <= '0;
    end else begin
      r_armed <= 1'b1;
      r_tog   <= bus.ps2_key[10];
      if (w_evt && w_lookup[KIDX_W])
        r_keys[w_lookup[KIDX_W-1:0]] <= bus.ps2_key[9];
    end
  end

  logic w_fire_src, w_fire_out, w_bomb, w_thrust, w_inviso;
  logic w_start1, w_start2, w_coin_req, w_coin_pulse;

  assign w_fire_src = r_keys[K_FIRE_A] | r_keys[K_FIRE_B] | w_joy[4];
  assign w_bomb     = r_keys[K_BOMB_A] | r_keys[K_BOMB_B];
  assign w_thrust   = r_keys[K_THR_A] | r_keys[K_THR_B] | r_keys[K_THR_C];
  assign w_inviso   = r_keys[K_INV_A] | r_keys[K_INV_B];
  assign w_start1   = r_keys[K_ST1_A] | r_keys[K_ST1_B];
  assign w_start2   = r_keys[K_ST2_A] | r_keys[K_ST2_B];
  // Joystick starts double as coin inserts.
  assign w_coin_req = r_keys[K_LCOIN] | r_keys[K_RCOIN_A] | r_keys[K_RCOIN_B]
                    | w_joy[9] | w_joy[10];

`ifdef INPUT_AUTOFIRE_EN
  logic [23:0] r_af_cnt;
  logic        r_af_off;

  // r_af_off=0 is the "high" phase so the first press cycle always fires.
  always_ff @(posedge clk_sys or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_af_cnt <= '0;
      r_af_off <= 1'b0;
    end else if (!w_fire_src) begin
      r_af_cnt <= '0;
      r_af_off <= 1'b0;
    end else if (r_af_cnt == AUTOFIRE_PERIOD - 24'd1) begin
      r_af_cnt <= '0;
      r_af_off <= ~r_af_off;
    end else begin
      r_af_cnt <= r_af_cnt + 24'd1;
    end
  end

  assign w_fire_out = w_fire_src & ~r_af_off;
`else
  assign w_fire_out = w_fire_src;
`endif

  williams_coin_pulse #(
    .COIN_HOLD (COIN_HOLD),
    .COIN_GAP  (COIN_GAP)
  ) u_coin (
    .clk_sys   (clk_sys),
    .I_RESET_N (I_RESET_N),
    .i_req     (w_coin_req),
    .o_pulse   (w_coin_pulse)
  );

  logic [8:0] w_ja_d, r_ja;
  logic [7:0] w_sw_d, r_sw;

  always_comb begin
    w_ja_d            = '0;
    w_ja_d[JA_START2] = w_start2 | w_joy[10];
    w_ja_d[JA_INVISO] = w_inviso | w_joy[7];
    w_ja_d[JA_UP]     = r_keys[K_UP] | w_joy[3];
    w_ja_d[JA_DOWN]   = r_keys[K_DOWN] | w_joy[2];
    w_ja_d[JA_REV]    = r_keys[K_REV] | w_joy[6];
    w_ja_d[JA_HYPER]  = r_keys[K_HYPER] | w_joy[8];
    w_ja_d[JA_BOMB]   = w_bomb | w_joy[5];
    w_ja_d[JA_THRUST] = w_thrust | w_joy[0] | w_joy[1];
    w_ja_d[JA_FIRE]   = w_fire_out;

    w_sw_d            = '0;
    w_sw_d[SW_START1] = w_start1 | w_joy[9];
    w_sw_d[SW_SLAM]   = r_keys[K_SLAM];
    w_sw_d[SW_COIN]   = w_coin_pulse;
    w_sw_d[SW_HSRST]  = r_keys[K_HSRST];
    w_sw_d[SW_ADV]    = r_keys[K_ADV];
    w_sw_d[SW_AUTOUP] = r_keys[K_AUTOUP];
  end

  always_ff @(posedge clk_sys or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_ja <= '0;
      r_sw <= '0;
    end else begin
      r_ja <= w_ja_d;
      r_sw <= w_sw_d;
    end
  end

  assign bus.JA = r_ja;
  assign bus.JB = r_ja;
  assign bus.SW = r_sw;

endmodule

// File: tb/tb_williams_input_mapper.sv
// Directed bench for williams_input_mapper with COIN_HOLD=COIN_GAP=8, AUTOFIRE_PERIOD=4.
module tb_williams_input_mapper;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic samp [0:159];

  williams_input_mapper_if bus();

  williams_input_mapper #(
    .COIN_HOLD       (24'd8),
    .COIN_GAP        (24'd8),
    .AUTOFIRE_PERIOD (24'd4)
  ) dut (
    .clk_sys   (clk),
    .I_RESET_N (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] j0;
    logic [15:0] j1;
    logic [8:0]  ja;
    logic [7:0]  sw;
  } joy_vec_t;

  typedef struct {
    logic        ext;
    logic [7:0]  code;
    logic [8:0]  ja;
    logic [7:0]  sw;
  } key_vec_t;

  joy_vec_t jv [13];
  key_vec_t kv [26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Toggle event set up before one rising edge; returns after that edge.
  task automatic send_key(input logic ext, input logic [7:0] code, input logic pr);
    logic t;
    @(negedge clk);
    t = ~bus.ps2_key[10];
    bus.ps2_key = {t, pr, ext, code};
    @(negedge clk);
  endtask

  task automatic analyze(input int n, output int rises, output int highs,
                         output int len1, output int gap1, output int len2);
    int rq[$];
    int fq[$];
    logic prev;
    prev  = 1'b0;
    highs = 0;
    for (int i = 0; i < n; i++) begin
      if (samp[i] && !prev) rq.push_back(i);
      if (!samp[i] && prev) fq.push_back(i);
      if (samp[i]) highs++;
      prev = samp[i];
    end
    rises = rq.size();
    len1 = (rq.size() > 0 && fq.size() > 0) ? fq[0] - rq[0] : -1;
    gap1 = (rq.size() > 1 && fq.size() > 0) ? rq[1] - fq[0] : -1;
    len2 = (rq.size() > 1 && fq.size() > 1) ? fq[1] - rq[1] : -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int rises, highs, len1, gap1, len2, sw7_low;
    logic exp_af;

    n_tests = 0;
    n_fail  = 0;

    jv[0]  = '{16'h0001, 16'h0000, 9'h002, 8'h00};
    jv[1]  = '{16'h0000, 16'h0002, 9'h002, 8'h00};
    jv[2]  = '{16'h0004, 16'h0000, 9'h020, 8'h00};
    jv[3]  = '{16'h0000, 16'h0008, 9'h040, 8'h00};
    jv[4]  = '{16'h0010, 16'h0000, 9'h001, 8'h00};
    jv[5]  = '{16'h0000, 16'h0020, 9'h004, 8'h00};
    jv[6]  = '{16'h0040, 16'h0000, 9'h010, 8'h00};
    jv[7]  = '{16'h0000, 16'h0080, 9'h080, 8'h00};
    jv[8]  = '{16'h0100, 16'h0000, 9'h008, 8'h00};
    jv[9]  = '{16'h0000, 16'h0200, 9'h000, 8'h80};
    jv[10] = '{16'h0400, 16'h0000, 9'h100, 8'h00};
    jv[11] = '{16'h0003, 16'h0001, 9'h002, 8'h00};
    jv[12] = '{16'hF800, 16'hF800, 9'h000, 8'h00};

    kv[0]  = '{1'b0, 8'h23, 9'h008, 8'h00};
    kv[1]  = '{1'b0, 8'h1D, 9'h001, 8'h00};
    kv[2]  = '{1'b0, 8'h14, 9'h001, 8'h00};
    kv[3]  = '{1'b0, 8'h1C, 9'h004, 8'h00};
    kv[4]  = '{1'b0, 8'h11, 9'h004, 8'h00};
    kv[5]  = '{1'b0, 8'h1B, 9'h002, 8'h00};
    kv[6]  = '{1'b1, 8'h6B, 9'h002, 8'h00};
    kv[7]  = '{1'b1, 8'h74, 9'h002, 8'h00};
    kv[8]  = '{1'b1, 8'h75, 9'h040, 8'h00};
    kv[9]  = '{1'b1, 8'h72, 9'h020, 8'h00};
    kv[10] = '{1'b0, 8'h29, 9'h010, 8'h00};
    kv[11] = '{1'b0, 8'h12, 9'h080, 8'h00};
    kv[12] = '{1'b0, 8'h59, 9'h080, 8'h00};
    kv[13] = '{1'b0, 8'h09, 9'h000, 8'h02};
    kv[14] = '{1'b0, 8'h01, 9'h000, 8'h01};
    kv[15] = '{1'b0, 8'h76, 9'h000, 8'h40};
    kv[16] = '{1'b0, 8'h83, 9'h000, 8'h04};
    kv[17] = '{1'b0, 8'h05, 9'h000, 8'h80};
    kv[18] = '{1'b0, 8'h16, 9'h000, 8'h80};
    kv[19] = '{1'b0, 8'h06, 9'h100, 8'h00};
    kv[20] = '{1'b0, 8'h1E, 9'h100, 8'h00};
    kv[21] = '{1'b0, 8'h04, 9'h000, 8'h00};
    kv[22] = '{1'b0, 8'h0C, 9'h000, 8'h00};
    kv[23] = '{1'b0, 8'h75, 9'h000, 8'h00};
    kv[24] = '{1'b1, 8'h23, 9'h000, 8'h00};
    kv[25] = '{1'b1, 8'h14, 9'h000, 8'h00};

    // Reset with toggle=1 and a fire press on the bus: must not create an event.
    rst_n       = 1'b0;
    bus.ps2_key = {1'b1, 1'b1, 1'b0, 8'h14};
    bus.joy_0   = '0;
    bus.joy_1   = '0;
    repeat (3) @(negedge clk);
    check("reset_ja", 32'(bus.JA), 32'h0);
    check("reset_sw", 32'(bus.SW), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_ja", 32'(bus.JA), 32'h0);
    check("post_reset_sw", 32'(bus.SW), 32'h0);

    // Joystick mapping, 1-cycle latency; coin bit masked here.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.joy_0 = jv[i].j0;
      bus.joy_1 = jv[i].j1;
      @(negedge clk);
      check($sformatf("joy%0d_ja", i), 32'(bus.JA), 32'(jv[i].ja));
      check($sformatf("joy%0d_jb", i), 32'(bus.JB), 32'(jv[i].ja));
      check($sformatf("joy%0d_sw", i), 32'(bus.SW & 8'hDF), 32'(jv[i].sw));
      bus.joy_0 = '0;
      bus.joy_1 = '0;
      @(negedge clk);
      check($sformatf("joy%0d_clear", i), 32'({bus.JA, bus.SW & 8'hDF}), 32'h0);
    end
    repeat (40) @(negedge clk);

    // Keyboard mapping: press then release, each checked two edges after the event.
    for (int i = 0; i < 26; i++) begin
      send_key(kv[i].ext, kv[i].code, 1'b1);
      @(negedge clk);
      check($sformatf("key%0d_ja", i), 32'(bus.JA), 32'(kv[i].ja));
      check($sformatf("key%0d_jb", i), 32'(bus.JB), 32'(kv[i].ja));
      check($sformatf("key%0d_sw", i), 32'(bus.SW & 8'hDF), 32'(kv[i].sw));
      send_key(kv[i].ext, kv[i].code, 1'b0);
      @(negedge clk);
      check($sformatf("key%0d_rel", i), 32'({bus.JA, bus.SW & 8'hDF}), 32'h0);
    end
    repeat (60) @(negedge clk);

    // Multi-key thrust: latency, then release of one key keeps thrust held.
    send_key(1'b1, 8'h6B, 1'b1);
    check("thrust_lat1", 32'(bus.JA[1]), 32'h0);
    @(negedge clk);
    check("thrust_lat2", 32'(bus.JA[1]), 32'h1);
    send_key(1'b1, 8'h74, 1'b1);
    send_key(1'b1, 8'h6B, 1'b0);
    @(negedge clk);
    check("thrust_or_hold", 32'(bus.JA[1]), 32'h1);
    send_key(1'b1, 8'h74, 1'b0);
    @(negedge clk);
    check("thrust_all_rel", 32'(bus.JA[1]), 32'h0);

    // Joystick start held 10*COIN_HOLD: one coin pulse only.
    @(negedge clk);
    bus.joy_1 = 16'h0200;
    sw7_low = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      samp[i] = bus.SW[5];
      if (!bus.SW[7]) sw7_low++;
    end
    bus.joy_1 = '0;
    for (int i = 80; i < 110; i++) begin
      @(negedge clk);
      samp[i] = bus.SW[5];
    end
    analyze(110, rises, highs, len1, gap1, len2);
    check("hold_sw7_low_cycles", 32'(sw7_low), 32'd0);
    check("hold_coin_rises", 32'(rises), 32'd1);
    check("hold_coin_highs", 32'(highs), 32'd8);
    check("hold_coin_width", 32'(len1), 32'd8);

    // rcoin press + two presses inside HOLD: second in-HOLD edge dropped.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          samp[i] = bus.SW[5];
        end
      end
      begin
        send_key(1'b0, 8'h2E, 1'b1);
        send_key(1'b0, 8'h2E, 1'b0);
        send_key(1'b0, 8'h2E, 1'b1);
        send_key(1'b0, 8'h2E, 1'b0);
        send_key(1'b0, 8'h2E, 1'b1);
        send_key(1'b0, 8'h2E, 1'b0);
      end
    join
    analyze(60, rises, highs, len1, gap1, len2);
    check("pend_rises", 32'(rises), 32'd2);
    check("pend_width1", 32'(len1), 32'd8);
    check("pend_gap", 32'(gap1), 32'd8);
    check("pend_width2", 32'(len2), 32'd8);
    repeat (20) @(negedge clk);

    // Reset mid-HOLD with a pending coin queued.
    send_key(1'b0, 8'h04, 1'b1);
    send_key(1'b0, 8'h04, 1'b0);
    send_key(1'b0, 8'h04, 1'b1);
    @(negedge clk);
    check("midhold_sw5", 32'(bus.SW[5]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sw", 32'(bus.SW), 32'h0);
    check("async_rst_ja", 32'(bus.JA), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      samp[i] = bus.SW[5];
    end
    analyze(40, rises, highs, len1, gap1, len2);
    check("post_rst_no_pulse", 32'(highs), 32'd0);
    send_key(1'b0, 8'h04, 1'b0);
    repeat (4) @(negedge clk);

`ifdef INPUT_AUTOFIRE_EN
    send_key(1'b0, 8'h14, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_af = (((k - 1) / 4) % 2) == 0;
      check($sformatf("autofire_c%0d", k), 32'(bus.JA[0]), 32'(exp_af));
    end
    send_key(1'b0, 8'h14, 1'b0);
    @(negedge clk);
    check("autofire_release", 32'(bus.JA[0]), 32'h0);
`else
    send_key(1'b0, 8'h14, 1'b1);
    exp_af = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("fire_steady_c%0d", k), 32'(bus.JA[0]), 32'(exp_af));
    end
    send_key(1'b0, 8'h14, 1'b0);
    @(negedge clk);
    check("fire_release", 32'(bus.JA[0]), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
